pen_locator: RTL and testbench

- Converts the raw light-pen photodiode signal into pixel write requests for the 8x8 bicolour frame buffer.
- Correlates pen hits with the pixel the scan driver is currently lighting, qualifies each hit by sampling it in a window, and emits a one-entry-buffered valid/ready write.
- Sits between the pen input (already inverted, active-high) and the frame-buffer write port of the LED scan driver.
- Also gated by the system state from the st state machine.

---
 rtl/pen_locator_pkg.sv | 33 +++
 rtl/pen_sync.sv | 29 ++
 rtl/pen_locator.sv | 165 ++++++++++++++++
 tb/tb_pen_locator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pen_locator_pkg.sv
// pen_locator_pkg: system state codes, locator FSM encoding and shared helpers.
// Rev 1.0
`default_nettype none

package pen_locator_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_SLEEP = 3'd1,
    ST_LIGHT = 3'd2,
    ST_DRAW  = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERASE = 3'd5,
    ST_COLOR = 3'd6,
    ST_STOP  = 3'd7
  } st_state_e;

  typedef enum logic [1:0] {
    PL_IDLE   = 2'd0,
    PL_SETTLE = 2'd1,
    PL_SAMPLE = 2'd2,
    PL_DECIDE = 2'd3
  } pl_state_e;

  localparam logic [1:0] COLOR_ERASE = 2'b00;

  function automatic logic st_write_en(input logic [2:0] s);
    return (s == ST_DRAW) || (s == ST_WRITE) || (s == ST_ERASE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pen_sync.sv
// pen_sync: two-flop synchroniser for the asynchronous pen detect input.
// Rev 1.0
`default_nettype none

module pen_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pen_locator.sv
// pen_locator: qualifies light-pen hits against the scanned pixel and issues buffered frame-buffer writes.
// Rev 1.0
`default_nettype none

module pen_locator
  import pen_locator_pkg::*;
#(
  parameter int unsigned HIT_DELAY = 4,
  parameter int unsigned HIT_WIN   = 8,
  parameter int unsigned HIT_MIN   = 5,
  parameter bit          DEDUP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state_i,
  input  logic       scan_strobe_i,
  input  logic [2:0] scan_row_i,
  input  logic [2:0] scan_col_i,
  input  logic       pen_hit_i,
  input  logic [1:0] pen_color_i,
  output logic       wr_valid_o,
  input  logic       wr_ready_i,
  output logic [5:0] wr_addr_o,
  output logic [1:0] wr_data_o,
  output logic [5:0] last_addr_o,
  output logic [7:0] drop_cnt_o
);

  localparam logic [3:0] DLY_LAST = 4'(HIT_DELAY - 1);
  localparam logic [3:0] WIN_LAST = 4'(HIT_WIN - 1);
  localparam logic [3:0] MIN_HITS = 4'(HIT_MIN);

  logic pen_s;

  pen_sync u_pen_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pen_hit_i),
    .q_o (pen_s)
  );

  pl_state_e  fsm_q, fsm_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [5:0] px_addr_q, px_addr_d;
  logic [1:0] px_data_q, px_data_d;
  logic       decide;

  logic       wr_valid_q;
  logic [5:0] wr_addr_q;
  logic [1:0] wr_data_q;
  logic [5:0] last_addr_q;
  logic [7:0] drop_cnt_q;
  logic       dedup_vld_q;
  logic [7:0] dedup_q;

  logic       wr_en;
  logic       accept;
  logic       dup;
  logic       load;
  logic       drop;

  assign wr_en = st_write_en(state_i);

  // A strobe always relatches: the most recent pixel wins, aborting any in flight.
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    hit_cnt_d = hit_cnt_q;
    px_addr_d = px_addr_q;
    px_data_d = px_data_q;
    decide    = 1'b0;
    if (!wr_en) begin
      fsm_d = PL_IDLE;
    end else if (scan_strobe_i) begin
      fsm_d     = PL_SETTLE;
      cnt_d     = 4'd0;
      px_addr_d = {scan_row_i, scan_col_i};
      px_data_d = (state_i == ST_ERASE) ? COLOR_ERASE : pen_color_i;
    end else begin
      case (fsm_q)
        PL_SETTLE: begin
          if (cnt_q == DLY_LAST) begin
            fsm_d     = PL_SAMPLE;
            cnt_d     = 4'd0;
            hit_cnt_d = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        PL_SAMPLE: begin
          hit_cnt_d = hit_cnt_q + {3'b000, pen_s};
          if (cnt_q == WIN_LAST) begin
            fsm_d = PL_DECIDE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        PL_DECIDE: begin
          decide = 1'b1;
          fsm_d  = PL_IDLE;
        end
        default: fsm_d = PL_IDLE;
      endcase
    end
  end

  always_comb begin
    accept = decide && (hit_cnt_q >= MIN_HITS);
    dup    = DEDUP && dedup_vld_q && (dedup_q == {px_addr_q, px_data_q});
    load   = accept && !dup && (!wr_valid_q || wr_ready_i);
    drop   = accept && !dup && !load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= PL_IDLE;
      cnt_q       <= 4'd0;
      hit_cnt_q   <= 4'd0;
      px_addr_q   <= 6'd0;
      px_data_q   <= 2'd0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 2'd0;
      last_addr_q <= 6'd0;
      drop_cnt_q  <= 8'd0;
      dedup_vld_q <= 1'b0;
      dedup_q     <= 8'd0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      hit_cnt_q <= hit_cnt_d;
      px_addr_q <= px_addr_d;
      px_data_q <= px_data_d;

      if (load) begin
        wr_valid_q  <= 1'b1;
        wr_addr_q   <= px_addr_q;
        wr_data_q   <= px_data_q;
        last_addr_q <= px_addr_q;
        dedup_vld_q <= 1'b1;
        dedup_q     <= {px_addr_q, px_data_q};
      end else if (wr_valid_q && wr_ready_i) begin
        wr_valid_q <= 1'b0;
      end

      // System-level reset state wipes statistics and the duplicate filter.
      if (state_i == ST_RST) begin
        drop_cnt_q  <= 8'd0;
        dedup_vld_q <= 1'b0;
      end else if (drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign last_addr_o = last_addr_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pen_locator.sv
// tb_pen_locator: directed self-checking bench for pen_locator.
// Rev 1.0
`default_nettype none

module tb_pen_locator;
  import pen_locator_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_i;
  logic       scan_strobe_i;
  logic [2:0] scan_row_i;
  logic [2:0] scan_col_i;
  logic       pen_hit_i;
  logic [1:0] pen_color_i;
  logic       wr_valid_o;
  logic       wr_ready_i;
  logic [5:0] wr_addr_o;
  logic [1:0] wr_data_o;
  logic [5:0] last_addr_o;
  logic [7:0] drop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pen_locator #(
    .HIT_DELAY (4),
    .HIT_WIN   (8),
    .HIT_MIN   (5),
    .DEDUP     (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .state_i       (state_i),
    .scan_strobe_i (scan_strobe_i),
    .scan_row_i    (scan_row_i),
    .scan_col_i    (scan_col_i),
    .pen_hit_i     (pen_hit_i),
    .pen_color_i   (pen_color_i),
    .wr_valid_o    (wr_valid_o),
    .wr_ready_i    (wr_ready_i),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .last_addr_o   (last_addr_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle k starts just after a rising edge; k=0 carries the strobe.
  // Pen is high for k in [h0,h1); an optional second strobe fires at k=s2.
  task automatic run_px(input logic [2:0] r, input logic [2:0] c,
                        input int h0, input int h1, input int ncyc,
                        input int s2, input logic [2:0] r2, input logic [2:0] c2,
                        output int first, output int nvalid,
                        output logic [5:0] faddr, output logic [1:0] fdata);
    first  = -1;
    nvalid = 0;
    faddr  = 6'd0;
    fdata  = 2'd0;
    for (int k = 0; k < ncyc; k++) begin
      scan_strobe_i = (k == 0) || (k == s2);
      scan_row_i    = (k == s2) ? r2 : r;
      scan_col_i    = (k == s2) ? c2 : c;
      pen_hit_i     = (k >= h0) && (k < h1);
      @(negedge clk);
      if (wr_valid_o) begin
        if (first < 0) begin
          first = k;
          faddr = wr_addr_o;
          fdata = wr_data_o;
        end
        nvalid++;
      end
      @(posedge clk);
      #1;
    end
    scan_strobe_i = 1'b0;
  endtask

  int         first;
  int         nvalid;
  logic [5:0] faddr;
  logic [1:0] fdata;
  int         stray;

  initial begin
    rst           = 1'b1;
    state_i       = ST_DRAW;
    scan_strobe_i = 1'b0;
    scan_row_i    = 3'd0;
    scan_col_i    = 3'd0;
    pen_hit_i     = 1'b0;
    pen_color_i   = 2'b01;
    wr_ready_i    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, wr_valid_o}, 32'd0);
    check("rst_addr", {26'd0, wr_addr_o}, 32'd0);
    check("rst_data", {30'd0, wr_data_o}, 32'd0);
    check("rst_last", {26'd0, last_addr_o}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_px(3'd3, 3'd5, 0, 100, 20, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    check("basic_lat", first, 32'd14);
    check("basic_len", nvalid, 32'd1);
    check("basic_addr", {26'd0, faddr}, 32'o35);
    check("basic_data", {30'd0, fdata}, 32'd1);
    check("basic_last", {26'd0, last_addr_o}, 32'o35);

    run_px(3'd1, 3'd1, 3, 7, 20, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    check("thr4_nowr", nvalid, 32'd0);
    run_px(3'd1, 3'd1, 3, 8, 20, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    check("thr5_lat", first, 32'd14);
    check("thr5_addr", {26'd0, faddr}, 32'o11);

    run_px(3'd2, 3'd2, 0, 100, 30, 6, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    check("restart_lat", first, 32'd20);
    check("restart_len", nvalid, 32'd1);
    check("restart_addr", {26'd0, faddr}, 32'd0);
    check("restart_data", {30'd0, fdata}, 32'd1);

    run_px(3'd0, 3'd0, 0, 100, 20, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    check("dedup_nowr", nvalid, 32'd0);

    state_i = ST_ERASE;
    run_px(3'd4, 3'd6, 0, 100, 20, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    check("erase_lat", first, 32'd14);
    check("erase_addr", {26'd0, faddr}, 32'o46);
    check("erase_data", {30'd0, fdata}, 32'd0);

    state_i = ST_SLEEP;
    run_px(3'd5, 3'd5, 0, 100, 20, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    check("sleep_nowr", nvalid, 32'd0);
    state_i = ST_DRAW;

    wr_ready_i = 1'b0;
    run_px(3'd6, 3'd1, 0, 100, 20, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    check("bp_first_lat", first, 32'd14);
    check("bp_first_held", nvalid, 32'd6);
    run_px(3'd6, 3'd2, 0, 100, 20, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    @(negedge clk);
    check("bp_valid", {31'd0, wr_valid_o}, 32'd1);
    check("bp_addr", {26'd0, wr_addr_o}, 32'o61);
    check("bp_data", {30'd0, wr_data_o}, 32'd1);
    check("bp_drop1", {24'd0, drop_cnt_o}, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      run_px(3'd6, 3'd2, 0, 100, 14, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    end
    @(negedge clk);
    check("drop_sat", {24'd0, drop_cnt_o}, 32'd255);
    check("bp_addr_kept", {26'd0, wr_addr_o}, 32'o61);
    @(posedge clk);
    #1;

    state_i = ST_RST;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("strst_drop", {24'd0, drop_cnt_o}, 32'd0);
    @(posedge clk);
    #1;
    state_i    = ST_DRAW;
    wr_ready_i = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("drain_valid", {31'd0, wr_valid_o}, 32'd0);
    @(posedge clk);
    #1;

    wr_ready_i = 1'b0;
    run_px(3'd7, 3'd7, 0, 100, 16, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    check("rstm_pending", first, 32'd14);
    run_px(3'd7, 3'd6, 0, 100, 7, -1, 3'd0, 3'd0, first, nvalid, faddr, fdata);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstm_valid", {31'd0, wr_valid_o}, 32'd0);
    check("rstm_addr", {26'd0, wr_addr_o}, 32'd0);
    check("rstm_data", {30'd0, wr_data_o}, 32'd0);
    check("rstm_last", {26'd0, last_addr_o}, 32'd0);
    check("rstm_drop", {24'd0, drop_cnt_o}, 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    wr_ready_i = 1'b1;
    stray      = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (wr_valid_o) stray++;
      @(posedge clk);
      #1;
    end
    check("rstm_nowr", stray, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
